// File: rtl/adder_serial_sequencer.sv
// Bit-serial adder sequencer: streams WIDTH-bit operand pairs LSB-first through an
// external 1-bit full adder, carrying between bits in a local register.
module adder_serial_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic             adder_a,
  output logic             adder_b,
  output logic             adder_cin,
  input  logic             adder_sumout,
  input  logic             adder_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = in_a;
          b_sr_d  = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {adder_sumout, sum_sr_q[WIDTH-1:1]};
        carry_d  = adder_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_valid ? sum_sr_q : '0;
  assign out_cout  = out_valid & carry_q;

  // Adder inputs come only from state and registers, keeping the adder loop registered.
  assign adder_a   = busy & a_sr_q[0];
  assign adder_b   = busy & b_sr_q[0];
  assign adder_cin = busy & carry_q;

endmodule

// File: tb/tb_adder_serial_sequencer.sv
// Bench for adder_serial_sequencer: directed vector table, randomized ops,
// streaming with a queue-based scoreboard, backpressure and reset-abort sequences.
module tb_adder_serial_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic         out_valid, out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout, busy;
  logic         adder_a, adder_b, adder_cin, adder_sumout, adder_cout;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int last_acc = 0;
  bit have_prev = 0;
  bit stream_on = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } op_t;
  op_t sbq[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    int           hold;
  } vec_t;
  vec_t tbl[8];

  adder_serial_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sumout(adder_sumout), .adder_cout(adder_cout)
  );

  // Behavioural 1-bit full adder primitive
  assign adder_sumout = adder_a ^ adder_b ^ adder_cin;
  assign adder_cout   = (adder_a & adder_b) | (adder_a & adder_cin) | (adder_b & adder_cin);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    int s;
    s = int'(a) + int'(b) + int'(cin);
    return (W+1)'(s);
  endfunction

  // Carry entering bit k is the overflow out of the k low-order bits.
  function automatic logic [W-1:0] carry_trace(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin);
    logic [W-1:0] t;
    int s;
    for (int k = 0; k < W; k++) begin
      s = (int'(a) % (1 << k)) + (int'(b) % (1 << k)) + int'(cin);
      t[k] = ((s >> k) != 0);
    end
    return t;
  endfunction

  // Scoreboard: accept/handoff observed on the falling edge before the active edge.
  always @(negedge clk) begin
    op_t o;
    logic [W:0] e;
    if (reset) begin
      sbq.delete();
      have_prev = 0;
    end else begin
      if (in_valid && in_ready) begin
        if (stream_on && have_prev) chk("accept_spacing", cyc - last_acc, W + 2);
        have_prev = stream_on;
        last_acc  = cyc;
        sbq.push_back('{in_a, in_b, in_cin});
      end
      if (out_valid && out_ready) begin
        chk("result_has_op", (sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          o = sbq.pop_front();
          e = model_add(o.a, o.b, o.cin);
          chk("sb_sum", out_sum, e[W-1:0]);
          chk("sb_cout", out_cout, e[W]);
          n_done++;
        end
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input int hold, input logic [W-1:0] es, input logic ec);
    logic [W-1:0] atr, btr, ctr, s0;
    logic         c0;
    int           lat, guard;
    bit           run_ok;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    lat = 0; run_ok = 1; atr = '0; btr = '0; ctr = '0;
    for (int k = 0; k < W; k++) begin
      atr[k] = adder_a; btr[k] = adder_b; ctr[k] = adder_cin;
      if (!busy || in_ready || out_valid) run_ok = 0;
      in_valid = (k < W - 1) ? 1'($urandom) : 1'b0;
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, W);
    chk("run_flags", run_ok, 1);
    chk("adder_a_bits", atr, a);
    chk("adder_b_bits", btr, b);
    chk("adder_cin_bits", ctr, carry_trace(a, b, cin));
    chk("out_sum", out_sum, es);
    chk("out_cout", out_cout, ec);
    s0 = out_sum; c0 = out_cout;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_stable", {out_cout, out_sum}, {c0, s0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("handoff_idle", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   e;
    int           d0, guard;
    bit           saw;

    tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 5};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0};
    tbl[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 2};
    tbl[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 0};
    tbl[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs",
        {in_ready, out_valid, busy, out_cout, adder_a, adder_b, adder_cin}, 7'b1000000);
    chk("rst_sum", out_sum, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].hold, tbl[i].s, tbl[i].c);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      e = model_add(ra, rb, rc);
      do_op(ra, rb, rc, int'($urandom_range(0, 3)), e[W-1:0], e[W]);
    end

    // Back-to-back streaming with operands changing every cycle
    d0 = n_done;
    stream_on = 1; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; stream_on = 0;
    guard = 0;
    while (!(in_ready && !busy) && guard < 40) begin @(posedge clk); #1; guard++; end
    chk("stream_drain", in_ready, 1);
    chk("stream_ops", n_done - d0, 7);
    out_ready = 1'b0;

    // Reset in the middle of RUN aborts the operation
    in_a = 8'h3C; in_b = 8'hC5; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("busy_before_abort", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_outputs",
        {in_ready, out_valid, busy, out_cout, adder_a, adder_b, adder_cin}, 7'b1000000);
    chk("abort_sum", out_sum, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid || busy) saw = 1;
      @(posedge clk); #1;
    end
    chk("no_valid_after_abort", saw, 0);
    out_ready = 1'b0;
    do_op(8'h01, 8'h01, 1'b0, 0, 8'h02, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_serial_sequencer.md
# adder_serial_sequencer

Bit-serial sequencer that time-shares one 1-bit full-adder primitive (A, B, CI → SUM, CO) to perform WIDTH-bit additions. It accepts a pair of operands over a valid/ready handshake and feeds the adder one bit per cycle, LSB first. It keeps the carry in a local register between bits and returns the assembled sum and final carry over a second valid/ready handshake. It sits in the logic-block tile beside the adder primitive and owns the adder's three inputs.

## Interface

- WIDTH, default 8: operand/sum width in bits. Legal range 2..32.
- CNT_W, default $clog2(WIDTH): bit-counter width. Derived; not overridden.
- clk  input  1  operating clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept an operand pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  initial carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  sum bits.
- out_cout  output  1  carry out of MSB.
- busy  output  1  high in RUN.
- adder_a  output  1  to adder A.
- adder_b  output  1  to adder B.
- adder_cin  output  1  to adder CI.
- adder_sumout  input  1  from adder SUM; combinational from adder_a/b/cin.
- adder_cout  input  1  from adder CO; combinational from adder_a/b/cin.

## Operation

- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE: in_ready=1. On in_valid & in_ready, load a_sr=in_a, b_sr=in_b, carry_q=in_cin, cnt=0, and go to RUN.
- RUN: in_ready=0, busy=1.
  - Drive adder_a=a_sr[0], adder_b=b_sr[0], adder_cin=carry_q.
  - Each edge: shift a_sr and b_sr right by 1; shift adder_sumout into the MSB of sum_sr (right shift); carry_q<=adder_cout; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, go to DONE.
- DONE: out_valid=1, out_sum=sum_sr, out_cout=carry_q. Both hold stable until out_ready. On out_valid & out_ready, go to IDLE.
- in_ready is 0 in DONE. No accept in the same cycle as result hand-off.
- In IDLE and DONE, adder_a, adder_b and adder_cin are driven 0.
- in_valid and operand inputs are ignored outside IDLE. Changes to them do not disturb an operation in flight.
- Width rule: out_sum = (in_a + in_b + in_cin) mod 2^WIDTH; out_cout = bit WIDTH of the full sum.

## Timing

- Reset (async assert; deassertion synchronized externally): state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, adder_a/b/cin=0, and all internal registers are 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. The pending result is discarded and no out_valid follows.
- Accept edge E0. RUN occupies the WIDTH cycles after E0. Bit k is presented to the adder during cycle k+1 after E0.
- out_valid rises at edge E0+WIDTH. Accept-to-valid latency is WIDTH cycles.
- With out_ready held high, throughput is one operation per WIDTH+2 cycles (1 IDLE + WIDTH RUN + 1 DONE).
- All outputs are registered or decoded from state and registers, except adder_a/b/cin. These three are decoded from state and shift registers, with no path from in_* or out_ready.
- The combinational loop adder_* → adder_sumout/cout is closed only through registers.

## Test plan

- WIDTH=8, in_a=0x5A, in_b=0x33, in_cin=0 → out_valid exactly 8 cycles after accept; out_sum=0x8D, out_cout=0.
- in_a=0xFF, in_b=0x01, in_cin=0 → out_sum=0x00, out_cout=1. Monitor adder_cin: 0 during bit 0, then 1 during bits 1..7.
- in_a=0xFF, in_b=0xFF, in_cin=1 → out_sum=0xFF, out_cout=1. in_ready=0 and busy=1 for all 8 RUN cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. out_valid, out_sum and out_cout stay stable, and in_ready stays 0. Raise out_ready for 1 cycle → IDLE and in_ready=1 on the next cycle.
- Keep in_valid high with changing operands during RUN, including back-to-back streaming. Each result matches only the operands sampled at its accept edge, and accepts are spaced WIDTH+2 cycles apart.
- Assert reset at RUN cycle 4. All outputs return to reset values asynchronously, and no out_valid appears. A new operation 0x01+0x01 then yields out_sum=0x02, out_cout=0.
